// File: rtl/password_lock.sv
// Four-digit BCD password controller with timed unlock, error and lockout holds.
// Seconds are taken from rising edges of the divider's slow square wave.
module password_lock #(
  parameter logic [15:0] PASSWORD  = 16'h1234,
  parameter int          MAX_TRIES = 3,
  parameter int          OPEN_SEC  = 5,
  parameter int          ERR_SEC   = 2,
  parameter int          LOCK_SEC  = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clk_div,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       clear,
  output logic       unlocked,
  output logic       error,
  output logic       lockout,
  output logic [2:0] digits_entered,
  output logic [3:0] fails,
  output logic [7:0] timer
);

  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, OPEN, ERROR, LOCKOUT
  } state_t;

  state_t      state, state_d;
  logic [15:0] code_q, code_d;
  logic [2:0]  cnt_d;
  logic [3:0]  fails_d;
  logic [7:0]  timer_d;

  logic [2:0] en_s, cl_s;
  logic       clk_div_q;
  logic       enter_p, clear_p, tick;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      en_s      <= '0;
      cl_s      <= '0;
      clk_div_q <= 1'b0;
    end else begin
      en_s      <= {en_s[1:0], enter};
      cl_s      <= {cl_s[1:0], clear};
      clk_div_q <= clk_div;
    end
  end

  assign enter_p = en_s[1] & ~en_s[2];
  assign clear_p = cl_s[1] & ~cl_s[2];
  assign tick    = clk_div & ~clk_div_q;

  always_comb begin
    state_d = state;
    code_d  = code_q;
    cnt_d   = digits_entered;
    fails_d = fails;
    timer_d = timer;
    unique case (state)
      IDLE, ENTRY: begin
        if (clear_p) begin
          code_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (enter_p && digit <= 4'd9) begin
          code_d  = {code_q[11:0], digit};
          cnt_d   = digits_entered + 3'd1;
          state_d = (digits_entered == 3'd3) ? CHECK : ENTRY;
        end
      end
      CHECK: begin
        code_d = '0;
        cnt_d  = '0;
        if (code_q == PASSWORD) begin
          state_d = OPEN;
          timer_d = 8'(OPEN_SEC);
          fails_d = '0;
        end else if ({1'b0, fails} + 5'd1 >= 5'(MAX_TRIES)) begin
          state_d = LOCKOUT;
          timer_d = 8'(LOCK_SEC);
          fails_d = 4'(MAX_TRIES);
        end else begin
          state_d = ERROR;
          timer_d = 8'(ERR_SEC);
          fails_d = fails + 4'd1;
        end
      end
      OPEN, ERROR, LOCKOUT: begin
        if (state == OPEN && clear_p) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (tick) begin
          if (timer <= 8'd1) begin
            timer_d = '0;
            state_d = IDLE;
            if (state == LOCKOUT) fails_d = '0;
          end else begin
            timer_d = timer - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      code_q         <= '0;
      digits_entered <= '0;
      fails          <= '0;
      timer          <= '0;
      unlocked       <= 1'b0;
      error          <= 1'b0;
      lockout        <= 1'b0;
    end else begin
      state          <= state_d;
      code_q         <= code_d;
      digits_entered <= cnt_d;
      fails          <= fails_d;
      timer          <= timer_d;
      unlocked       <= (state_d == OPEN);
      error          <= (state_d == ERROR);
      lockout        <= (state_d == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_password_lock.sv
// Bench for password_lock: digit-count changes are scoreboarded,
// status outputs and timers are checked inline by each scenario task.
module tb_password_lock;

  localparam int OPEN_SEC = 5;
  localparam int ERR_SEC  = 2;
  localparam int LOCK_SEC = 10;

  logic       CLK = 0;
  logic       RST = 0;
  logic       clk_div = 0;
  logic [3:0] digit = 0;
  logic       enter = 0;
  logic       clear = 0;
  logic       unlocked, error, lockout;
  logic [2:0] digits_entered;
  logic [3:0] fails;
  logic [7:0] timer;

  int n_cmp = 0;
  int n_bad = 0;
  int de_q[$];
  logic [2:0] prev_de = 0;

  password_lock dut (
    .CLK(CLK), .RST(RST), .clk_div(clk_div), .digit(digit),
    .enter(enter), .clear(clear), .unlocked(unlocked),
    .error(error), .lockout(lockout),
    .digits_entered(digits_entered), .fails(fails), .timer(timer)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (digits_entered !== prev_de) begin
      n_cmp++;
      if (de_q.size() == 0) begin
        n_bad++;
        $display("FAIL de_sb: digits_entered %0d -> %0d, required no change",
                 prev_de, digits_entered);
      end else begin
        int e;
        e = de_q.pop_front();
        if (digits_entered !== 3'(e)) begin
          n_bad++;
          $display("FAIL de_sb: digits_entered=%0d required %0d",
                   digits_entered, e);
        end
      end
      prev_de = digits_entered;
    end
  end

  task automatic wait_neg(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(logic [3:0] d);
    digit = d;
    enter = 1;
    wait_neg(4);
    enter = 0;
    wait_neg(3);
  endtask

  task automatic tick_n(int n);
    repeat (n) begin
      clk_div = 1;
      wait_neg(2);
      clk_div = 0;
      wait_neg(2);
    end
  endtask

  task automatic enter_code(logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      de_q.push_back(i + 1);
      if (i == 3) de_q.push_back(0);
      press(code[15 - 4 * i -: 4]);
    end
  endtask

  task automatic apply_reset();
    RST = 0;
    wait_neg(2);
    RST = 1;
    wait_neg(2);
  endtask

  task automatic test_reset();
    wait_neg(2);
    n_cmp++;
    if ({unlocked, error, lockout, digits_entered, fails, timer} !== 18'd0) begin
      n_bad++;
      $display("FAIL reset: outs=%b required 0",
               {unlocked, error, lockout, digits_entered, fails, timer});
    end
    RST = 1;
    wait_neg(2);
  endtask

  task automatic test_unlock();
    enter_code(16'h1234);
    n_cmp++;
    if (unlocked !== 1 || timer !== 8'(OPEN_SEC)) begin
      n_bad++;
      $display("FAIL unlock: unlocked=%0d timer=%0d required 1/%0d",
               unlocked, timer, OPEN_SEC);
    end
    for (int i = 1; i <= OPEN_SEC; i++) begin
      tick_n(1);
      n_cmp++;
      if (timer !== 8'(OPEN_SEC - i)) begin
        n_bad++;
        $display("FAIL open_tick%0d: timer=%0d required %0d",
                 i, timer, OPEN_SEC - i);
      end
    end
    n_cmp++;
    if (unlocked !== 0) begin
      n_bad++;
      $display("FAIL relock: unlocked=%0d required 0", unlocked);
    end
  endtask

  task automatic test_error();
    enter_code(16'h1235);
    n_cmp++;
    if (error !== 1 || fails !== 4'd1 || timer !== 8'(ERR_SEC)) begin
      n_bad++;
      $display("FAIL error: err=%0d fails=%0d timer=%0d required 1/1/%0d",
               error, fails, timer, ERR_SEC);
    end
    tick_n(ERR_SEC);
    n_cmp++;
    if (error !== 0 || timer !== 0) begin
      n_bad++;
      $display("FAIL error_end: err=%0d timer=%0d required 0/0", error, timer);
    end
    de_q.push_back(1);
    press(4'd7);
    de_q.push_back(0);
    clear = 1;
    wait_neg(4);
    clear = 0;
    wait_neg(3);
  endtask

  task automatic test_lockout();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      enter_code(16'h9999);
      if (k < 2) tick_n(ERR_SEC);
    end
    n_cmp++;
    if (lockout !== 1 || fails !== 4'd3 || timer !== 8'(LOCK_SEC)) begin
      n_bad++;
      $display("FAIL lockout: lk=%0d fails=%0d timer=%0d required 1/3/%0d",
               lockout, fails, timer, LOCK_SEC);
    end
    press(4'd1);
    press(4'd2);
    n_cmp++;
    if (digits_entered !== 0) begin
      n_bad++;
      $display("FAIL lock_enter: digits_entered=%0d required 0", digits_entered);
    end
    tick_n(LOCK_SEC);
    n_cmp++;
    if (lockout !== 0 || fails !== 0 || timer !== 0) begin
      n_bad++;
      $display("FAIL lock_end: lk=%0d fails=%0d timer=%0d required 0/0/0",
               lockout, fails, timer);
    end
  endtask

  task automatic test_clear();
    de_q.push_back(1);
    press(4'd1);
    de_q.push_back(2);
    press(4'd2);
    de_q.push_back(0);
    clear = 1;
    wait_neg(4);
    clear = 0;
    wait_neg(3);
    enter_code(16'h1234);
    n_cmp++;
    if (unlocked !== 1) begin
      n_bad++;
      $display("FAIL clear_unlock: unlocked=%0d required 1", unlocked);
    end
    tick_n(OPEN_SEC);
    de_q.push_back(1);
    press(4'd5);
    de_q.push_back(0);
    digit = 4'd6;
    enter = 1;
    clear = 1;
    wait_neg(4);
    enter = 0;
    clear = 0;
    wait_neg(3);
    n_cmp++;
    if (digits_entered !== 0) begin
      n_bad++;
      $display("FAIL both: digits_entered=%0d required 0", digits_entered);
    end
  endtask

  task automatic test_bad_digit_and_relock();
    de_q.push_back(1);
    press(4'd1);
    press(4'hA);
    n_cmp++;
    if (digits_entered !== 1) begin
      n_bad++;
      $display("FAIL bad_digit: digits_entered=%0d required 1", digits_entered);
    end
    de_q.push_back(0);
    clear = 1;
    wait_neg(4);
    clear = 0;
    wait_neg(3);
    enter_code(16'h1234);
    clear = 1;
    begin
      int c;
      c = 0;
      while (unlocked !== 0 && c < 4) begin
        wait_neg(1);
        c++;
      end
    end
    n_cmp++;
    if (unlocked !== 0 || timer !== 0) begin
      n_bad++;
      $display("FAIL clr_open: unlocked=%0d timer=%0d required 0/0",
               unlocked, timer);
    end
    clear = 0;
    wait_neg(3);
  endtask

  task automatic test_reset_mid_lockout();
    for (int k = 0; k < 3; k++) begin
      enter_code(16'h5555);
      if (k < 2) tick_n(ERR_SEC);
    end
    tick_n(4);
    n_cmp++;
    if (lockout !== 1 || timer !== 8'd6) begin
      n_bad++;
      $display("FAIL pre_rst: lk=%0d timer=%0d required 1/6", lockout, timer);
    end
    RST = 0;
    wait_neg(1);
    n_cmp++;
    if ({unlocked, error, lockout, digits_entered, fails, timer} !== 18'd0) begin
      n_bad++;
      $display("FAIL mid_rst: outs=%b required 0",
               {unlocked, error, lockout, digits_entered, fails, timer});
    end
    RST = 1;
    wait_neg(2);
    enter_code(16'h1234);
    n_cmp++;
    if (unlocked !== 1 || timer !== 8'(OPEN_SEC)) begin
      n_bad++;
      $display("FAIL rst_unlock: unlocked=%0d timer=%0d required 1/%0d",
               unlocked, timer, OPEN_SEC);
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_error();
    test_lockout();
    test_clear();
    test_bad_digit_and_relock();
    test_reset_mid_lockout();
    wait_neg(2);
    n_cmp++;
    if (de_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d pending, required 0", de_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
